// File: rtl/exposure_timer.sv
// Exposure timer: times a Start-triggered exposure of a latched length and pulses Ovf5 when it ends.
// Also holds the button-adjusted exposure time, clamped to [EXP_MIN, EXP_MAX].
module exposure_timer #(
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 2,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  output logic             Ovf5,
  output logic             Busy,
  output logic [CNT_W-1:0] Exp_time,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             inc_h_q, dec_h_q;
  logic             inc_e, dec_e;

  assign inc_e = Exp_increase & ~inc_h_q;
  assign dec_e = Exp_decrease & ~dec_h_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    exp_d   = exp_q;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous edges cancel; button edges outside IDLE are dropped.
        if (inc_e && !dec_e && exp_q < CNT_W'(EXP_MAX))
          exp_d = exp_q + CNT_W'(1);
        else if (dec_e && !inc_e && exp_q > CNT_W'(EXP_MIN))
          exp_d = exp_q - CNT_W'(1);
        if (Start) begin
          state_d = COUNT;
          cnt_d   = '0;
          len_d   = exp_q;
        end
      end
      COUNT: begin
        if (cnt_q == len_q - CNT_W'(1)) begin
          state_d = DONE;
          ovf_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= CNT_W'(EXP_DEFAULT);
      exp_q   <= CNT_W'(EXP_DEFAULT);
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      inc_h_q <= 1'b0;
      dec_h_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      inc_h_q <= Exp_increase;
      dec_h_q <= Exp_decrease;
    end
  end

  assign Ovf5     = ovf_q;
  assign Busy     = busy_q;
  assign Exp_time = exp_q;
  assign Count    = cnt_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Scoreboard bench for exposure_timer: an edge-numbered reference model predicts outputs,
// a monitor process pops and compares them after every clock edge.
module tb_exposure_timer;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset, Start, Exp_increase, Exp_decrease;
  logic             Ovf5, Busy;
  logic [CNT_W-1:0] Exp_time, Count;

  exposure_timer #(.EXP_MIN(2), .EXP_MAX(30), .EXP_DEFAULT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Start(Start),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Ovf5(Ovf5), .Busy(Busy), .Exp_time(Exp_time), .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic busy;
    logic ovf;
    int   cnt;
    int   expt;
  } exp_t;

  exp_t expq[$];
  int   ovfq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: an exposure started at edge s with length T occupies edges s..s+T,
  // Ovf5 fires after edge s+T, and the block is ready for a new Start at edge s+T+2.
  int   n = 0;
  bit   has_s = 0;
  int   s = 0, T = 0;
  int   m_exp = 2;
  bit   m_inc_h = 0, m_dec_h = 0;

  task automatic step(input bit rst_n, input bit st, input bit inc, input bit dec);
    exp_t e;
    bit   idle, ie, de;
    reset = rst_n; Start = st; Exp_increase = inc; Exp_decrease = dec;
    if (!rst_n) begin
      has_s = 0; m_exp = 2; m_inc_h = 0; m_dec_h = 0;
      ovfq.delete();
    end else begin
      idle = !has_s || (n >= s + T + 2);
      ie = inc && !m_inc_h;
      de = dec && !m_dec_h;
      if (idle) begin
        if (st) begin
          has_s = 1; s = n; T = m_exp;
          ovfq.push_back(s + T);
        end
        if (ie && !de) m_exp = (m_exp + 1 > 30) ? 30 : m_exp + 1;
        if (de && !ie) m_exp = (m_exp - 1 < 2) ? 2 : m_exp - 1;
      end
      m_inc_h = inc; m_dec_h = dec;
    end
    e.n    = n;
    e.busy = has_s && (n >= s) && (n <= s + T);
    e.ovf  = has_s && (n == s + T);
    e.cnt  = (has_s && n >= s && n < s + T) ? n - s : 0;
    e.expt = m_exp;
    expq.push_back(e);
    @(posedge clk);
    #1;
    n++;
  endtask

  // Monitor: counts edges independently and checks after each one.
  int mon_n = 0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    n_cmp++;
    if (expq.size() == 0) begin
      n_err++;
      $display("FAIL state edge %0d: no expected entry", mon_n);
    end else begin
      e = expq.pop_front();
      if (e.n != mon_n || Busy !== e.busy || Ovf5 !== e.ovf ||
          Count !== CNT_W'(e.cnt) || Exp_time !== CNT_W'(e.expt)) begin
        n_err++;
        $display("FAIL state edge %0d: got busy=%b ovf=%b cnt=%0d exp=%0d, want busy=%b ovf=%b cnt=%0d exp=%0d",
                 mon_n, Busy, Ovf5, Count, Exp_time, e.busy, e.ovf, e.cnt, e.expt);
      end
    end
    if (Ovf5 === 1'b1) begin
      n_cmp++;
      if (ovfq.size() == 0) begin
        n_err++;
        $display("FAIL ovf edge %0d: unexpected pulse, want none", mon_n);
      end else if (ovfq[0] != mon_n) begin
        n_err++;
        $display("FAIL ovf edge %0d: pulse got at %0d, want at %0d", mon_n, mon_n, ovfq[0]);
        void'(ovfq.pop_front());
      end else begin
        void'(ovfq.pop_front());
      end
    end
    mon_n++;
  end

  initial begin
    reset = 0; Start = 0; Exp_increase = 0; Exp_decrease = 0;
    // Reset for two edges, then idle.
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    // Minimum exposure, T=2.
    step(1, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    // Five separate increase pulses, then a held increase.
    repeat (5) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
    repeat (10) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    // Saturate high and low.
    repeat (40) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
    repeat (40) begin step(1, 0, 0, 1); step(1, 0, 0, 0); end
    repeat (3) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
    step(1, 0, 1, 1); step(1, 0, 0, 0);
    // T=4 exposure with Start and buttons thrown at it while busy.
    step(1, 0, 0, 1); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 1, 1, 0); step(1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    // T=6 exposure aborted by reset at Count==3.
    repeat (2) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (10) step(1, 0, 0, 0);
    // Back-to-back exposures with Start held high.
    repeat (12) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 299) != 0, ($urandom % 6) == 0,
           ($urandom % 3) == 0, ($urandom % 3) == 0);
    repeat (40) step(1, 0, 0, 0);
    #5;
    n_cmp++;
    if (ovfq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pulses outstanding, want 0", ovfq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
